// File: rtl/fetch_redirect_if.sv
// Fetch front-end bundle: hazard/redirect inputs, instruction-memory request/response,
// and the decode hand-off slot. The fetch unit is the master; its environment is the slave.
interface fetch_redirect_if;
  logic        stop;
  logic        br0_flag;
  logic        br0_num;
  logic [31:0] br0_addr;
  logic        br1_flag;
  logic        br1_num;
  logic [31:0] br1_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_npc;
  logic [31:0] if_inst;

  modport master (
    input  stop, br0_flag, br0_num, br0_addr, br1_flag, br1_num, br1_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_npc, if_inst
  );

  modport slave (
    output stop, br0_flag, br0_num, br0_addr, br1_flag, br1_num, br1_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_npc, if_inst
  );
endinterface

// File: rtl/fetch_redirect.sv
// Instruction-fetch front end: owns the PC, issues in-order memory requests under a credit
// limit, buffers returned words with their PCs, and restarts fetch on a branch redirect.
module fetch_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_redirect_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc_r;
  logic [31:0]   buf_pc_r   [DEPTH];
  logic [31:0]   buf_inst_r [DEPTH];
  logic [31:0]   tag_r      [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] tag_rd_r;
  logic [PW-1:0] tag_wr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] inflight_r;
  // Discards can outlive several redirects, so give them one spare bit of headroom.
  logic [CW:0]   discard_r;
  logic          running_r;

  logic          redir_s;
  logic [31:0]   target_s;
  logic [CW:0]   used_s;
  logic          req_valid_s;
  logic          fire_s;
  logic          take_s;
  logic          drop_s;
  logic          if_valid_s;
  logic          pop_s;

  // Redirect arbitration: older instruction (num 0) wins, br0 breaks ties.
  always_comb begin
    redir_s  = bus.br0_flag | bus.br1_flag;
    target_s = 32'h0000_0000;
    if (bus.br0_flag && bus.br1_flag) begin
      if (!bus.br1_num && bus.br0_num) begin
        target_s = bus.br1_addr & 32'hFFFF_FFFC;
      end else begin
        target_s = bus.br0_addr & 32'hFFFF_FFFC;
      end
    end else if (bus.br1_flag) begin
      target_s = bus.br1_addr & 32'hFFFF_FFFC;
    end else begin
      target_s = bus.br0_addr & 32'hFFFF_FFFC;
    end
  end

  // Issue, capture and hand-off qualifiers.
  always_comb begin
    used_s      = {1'b0, count_r} + {1'b0, inflight_r};
    req_valid_s = running_r && !redir_s && !bus.stop && (used_s < DEPTH_W);
    fire_s      = req_valid_s && bus.imem_req_ready;
    drop_s      = bus.imem_resp_valid && (discard_r != {(CW+1){1'b0}});
    take_s      = bus.imem_resp_valid && (discard_r == {(CW+1){1'b0}}) && !redir_s;
    if_valid_s  = (count_r != {CW{1'b0}}) && !redir_s && !bus.stop;
    pop_s       = if_valid_s && bus.if_ready;
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = pc_r;
  assign bus.if_valid       = if_valid_s;
  assign bus.if_pc          = buf_pc_r[rd_ptr_r];
  assign bus.if_npc         = buf_pc_r[rd_ptr_r] + 32'd4;
  assign bus.if_inst        = buf_inst_r[rd_ptr_r];

  // PC, tag FIFO, fetch buffer and credit counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      tag_rd_r   <= {PW{1'b0}};
      tag_wr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      inflight_r <= {CW{1'b0}};
      discard_r  <= {(CW+1){1'b0}};
      running_r  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_r[i]   <= 32'h0000_0000;
        buf_inst_r[i] <= 32'h0000_0000;
        tag_r[i]      <= 32'h0000_0000;
      end
    end else begin
      running_r <= 1'b1;
      if (redir_s) begin
        // Everything younger than the branch is squashed; outstanding words become discards.
        pc_r       <= target_s;
        rd_ptr_r   <= {PW{1'b0}};
        wr_ptr_r   <= {PW{1'b0}};
        tag_rd_r   <= {PW{1'b0}};
        tag_wr_r   <= {PW{1'b0}};
        count_r    <= {CW{1'b0}};
        inflight_r <= {CW{1'b0}};
        discard_r  <= discard_r + {1'b0, inflight_r} - {{CW{1'b0}}, bus.imem_resp_valid};
      end else begin
        if (fire_s) begin
          tag_r[tag_wr_r] <= pc_r;
          tag_wr_r        <= tag_wr_r + PTR_ONE;
          pc_r            <= pc_r + 32'd4;
        end
        if (take_s) begin
          buf_pc_r[wr_ptr_r]   <= tag_r[tag_rd_r];
          buf_inst_r[wr_ptr_r] <= bus.imem_resp_data;
          wr_ptr_r             <= wr_ptr_r + PTR_ONE;
          tag_rd_r             <= tag_rd_r + PTR_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        count_r    <= count_r + {{PW{1'b0}}, take_s} - {{PW{1'b0}}, pop_s};
        inflight_r <= inflight_r + {{PW{1'b0}}, fire_s} - {{PW{1'b0}}, take_s};
        discard_r  <= discard_r - {{CW{1'b0}}, drop_s};
      end
    end
  end

endmodule
